// File: rtl/tdm_demux_if.sv
// Stream and frame bundle for the TDM receive demultiplexer.
// The master side owns the incoming sample stream and observes the
// published frame; the slave side is the demultiplexer itself.
interface tdm_demux_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    localparam int SLOT_W = $clog2(CHANNELS);

    logic                      in_valid;
    logic                      in_sync;
    logic [WIDTH-1:0]          in_data;
    logic [SLOT_W-1:0]         slot;
    logic [CHANNELS*WIDTH-1:0] ch_data;
    logic                      frame_valid;
    logic                      sync_err;
    logic [7:0]                frame_cnt;

    modport master (
        output in_valid,
        output in_sync,
        output in_data,
        input  slot,
        input  ch_data,
        input  frame_valid,
        input  sync_err,
        input  frame_cnt
    );

    modport slave (
        input  in_valid,
        input  in_sync,
        input  in_data,
        output slot,
        output ch_data,
        output frame_valid,
        output sync_err,
        output frame_cnt
    );
endinterface

// File: rtl/tdm_demux.sv
// Receive-side time-division demultiplexer.
// Sample k of each frame lands in staging slot k; when the last slot is
// filled the whole staging buffer is published on ch_data in one edge, so
// consumers only ever see complete frames. HUNT waits for a sync-marked
// sample before filling; RUN tracks alignment and flags framing errors.
module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input logic         clk,
    input logic         rst,
    tdm_demux_if.slave  bus
);
    localparam int                SLOT_W    = $clog2(CHANNELS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    typedef enum logic {
        HUNT,
        RUN
    } state_t;

    state_t                           state;
    state_t                           state_nxt;
    logic [SLOT_W-1:0]                slot_q;
    logic [SLOT_W-1:0]                slot_nxt;
    logic [CHANNELS-1:0][WIDTH-1:0]   staging;
    logic [CHANNELS-1:0][WIDTH-1:0]   staging_nxt;
    logic [CHANNELS*WIDTH-1:0]        ch_q;
    logic                             fv_q;
    logic                             err_q;
    logic [7:0]                       cnt_q;

    logic                             wr_en;
    logic [SLOT_W-1:0]                wr_idx;
    logic                             publish;
    logic                             err_det;

    // Alignment FSM: decides where an accepted sample goes, whether it
    // closes a frame, and whether it reveals a framing violation.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_q;
        wr_en     = 1'b0;
        wr_idx    = slot_q;
        publish   = 1'b0;
        err_det   = 1'b0;

        if (bus.in_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.in_sync) begin
                        wr_en     = 1'b1;
                        wr_idx    = '0;
                        slot_nxt  = SLOT_ONE;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (bus.in_sync) begin
                        wr_en    = 1'b1;
                        wr_idx   = '0;
                        slot_nxt = SLOT_ONE;
                        err_det  = (slot_q != '0);
                    end else if (slot_q == '0) begin
                        err_det   = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = slot_q;
                        if (slot_q == LAST_SLOT) begin
                            publish  = 1'b1;
                            slot_nxt = '0;
                        end else begin
                            slot_nxt = slot_q + SLOT_ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    slot_nxt  = '0;
                end
            endcase
        end
    end

    // Merge the incoming sample into the staging image so the publish edge
    // can capture a frame that already contains its final sample.
    always_comb begin
        staging_nxt = staging;
        if (wr_en) begin
            staging_nxt[wr_idx] = bus.in_data;
        end
    end

    // FSM state and slot pointer; reset drops alignment immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= HUNT;
            slot_q <= '0;
        end else begin
            state  <= state_nxt;
            slot_q <= slot_nxt;
        end
    end

    // Staging buffer, published frame, status pulses and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging <= '0;
            ch_q    <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            staging <= staging_nxt;
            fv_q    <= publish;
            err_q   <= err_det;
            if (publish) begin
                ch_q  <= staging_nxt;
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign bus.slot        = slot_q;
    assign bus.ch_data     = ch_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = err_q;
    assign bus.frame_cnt   = cnt_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with a cycle-accurate expectation queue.
// Each driven cycle pushes the outputs expected after the next edge; a
// monitor pops one entry per edge and compares every output.
module tb_tdm_demux;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int SW = $clog2(CH);

    typedef struct packed {
        logic          fv;
        logic          err;
        logic [SW-1:0] slot;
        logic [CH*W-1:0] ch;
        logic [7:0]    cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    tdm_demux_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    exp_t            sbq[$];
    int              compared   = 0;
    int              mismatched = 0;
    int              fv_seen    = 0;
    int              err_seen   = 0;

    // Reference model of the receiver.
    bit              m_run;
    int              m_slot;
    logic [W-1:0]    m_stage[CH];
    logic [CH*W-1:0] m_ch;
    logic [7:0]      m_cnt;

    // One comparison: count it, and on difference count and report it.
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Return the model to its post-reset condition.
    task automatic modelReset();
        m_run  = 1'b0;
        m_slot = 0;
        for (int k = 0; k < CH; k++) m_stage[k] = '0;
        m_ch   = '0;
        m_cnt  = '0;
        sbq.delete();
    endtask

    // Drive one cycle of stream input and queue the outputs expected after
    // the edge that consumes it.
    task automatic applyStimulus(input logic v, input logic s, input logic [W-1:0] d);
        exp_t e;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_data  = d;
        e.fv  = 1'b0;
        e.err = 1'b0;
        if (v) begin
            if (!m_run) begin
                if (s) begin
                    m_stage[0] = d;
                    m_slot     = 1;
                    m_run      = 1'b1;
                end
            end else if (s) begin
                if (m_slot != 0) e.err = 1'b1;
                m_stage[0] = d;
                m_slot     = 1;
            end else if (m_slot == 0) begin
                e.err = 1'b1;
                m_run = 1'b0;
            end else begin
                m_stage[m_slot] = d;
                if (m_slot == CH - 1) begin
                    for (int k = 0; k < CH; k++) m_ch[k*W +: W] = m_stage[k];
                    e.fv   = 1'b1;
                    m_cnt  = m_cnt + 8'd1;
                    m_slot = 0;
                end else begin
                    m_slot = m_slot + 1;
                end
            end
        end
        e.slot = SW'(m_slot);
        e.ch   = m_ch;
        e.cnt  = m_cnt;
        sbq.push_back(e);
    endtask

    // An idle cycle with junk on the data and sync lines.
    task automatic idleCycle();
        logic [W-1:0] junk;
        junk = 8'($urandom);
        applyStimulus(1'b0, 1'($urandom), junk);
    endtask

    // Send a whole frame, slot 0 first, with idle gaps after each sample.
    task automatic sendFrame(input logic [CH*W-1:0] f, input int gap);
        for (int k = 0; k < CH; k++) begin
            applyStimulus(1'b1, (k == 0), f[k*W +: W]);
            repeat (gap) idleCycle();
        end
    endtask

    // Synchronous-looking reset pulse placed away from clock edges.
    task automatic doReset();
        @(negedge clk);
        #2;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = '0;
        modelReset();
        #1;
        checkOutput("rst_ch_data", 64'(bus.ch_data), 64'd0);
        checkOutput("rst_slot", 64'(bus.slot), 64'd0);
        checkOutput("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
        checkOutput("rst_sync_err", 64'(bus.sync_err), 64'd0);
        checkOutput("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        @(negedge clk);
        #3;
        rst = 1'b0;
    endtask

    // Monitor: just after each edge, compare outputs to the queued entry.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("frame_valid", 64'(bus.frame_valid), 64'(e.fv));
            checkOutput("sync_err", 64'(bus.sync_err), 64'(e.err));
            checkOutput("slot", 64'(bus.slot), 64'(e.slot));
            checkOutput("ch_data", 64'(bus.ch_data), 64'(e.ch));
            checkOutput("frame_cnt", 64'(bus.frame_cnt), 64'(e.cnt));
            if (bus.frame_valid === 1'b1) fv_seen++;
            if (bus.sync_err === 1'b1) err_seen++;
        end
    end

    // Directed test sequence.
    initial begin
        int fv0;
        int err0;
        logic [CH*W-1:0] f;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = '0;
        modelReset();
        #3;
        checkOutput("por_ch_data", 64'(bus.ch_data), 64'd0);
        checkOutput("por_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        #19;
        rst = 1'b0;

        // Normal back-to-back frame.
        $display("[TB] normal frame");
        fv0 = fv_seen;
        sendFrame(32'h44332211, 0);
        idleCycle();
        checkOutput("normal_ch_data", 64'(bus.ch_data), 64'h44332211);
        checkOutput("normal_frame_valid", 64'(bus.frame_valid), 64'd1);
        checkOutput("normal_frame_cnt", 64'(bus.frame_cnt), 64'd1);
        checkOutput("normal_slot", 64'(bus.slot), 64'd0);
        idleCycle();
        checkOutput("normal_fv_pulses", 64'(fv_seen - fv0), 64'd1);

        // Gapped frames.
        $display("[TB] gapped frames");
        doReset();
        fv0  = fv_seen;
        err0 = err_seen;
        sendFrame(32'h44332211, 3);
        checkOutput("gap_first_ch_data", 64'(bus.ch_data), 64'h44332211);
        sendFrame(32'hA4A3A2A1, 3);
        idleCycle();
        checkOutput("gap_second_ch_data", 64'(bus.ch_data), 64'hA4A3A2A1);
        checkOutput("gap_frame_cnt", 64'(bus.frame_cnt), 64'd2);
        checkOutput("gap_fv_pulses", 64'(fv_seen - fv0), 64'd2);
        checkOutput("gap_err_pulses", 64'(err_seen - err0), 64'd0);

        // Hunt: unsynced samples are dropped silently.
        $display("[TB] hunt");
        doReset();
        err0 = err_seen;
        applyStimulus(1'b1, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b0, 8'h66);
        sendFrame(32'h04030201, 0);
        idleCycle();
        checkOutput("hunt_ch_data", 64'(bus.ch_data), 64'h04030201);
        checkOutput("hunt_err_pulses", 64'(err_seen - err0), 64'd0);

        // Early sync restarts the frame.
        $display("[TB] early sync");
        doReset();
        fv0  = fv_seen;
        err0 = err_seen;
        applyStimulus(1'b1, 1'b1, 8'h10);
        applyStimulus(1'b1, 1'b0, 8'h20);
        sendFrame(32'h60504030, 0);
        idleCycle();
        checkOutput("early_ch_data", 64'(bus.ch_data), 64'h60504030);
        checkOutput("early_fv_pulses", 64'(fv_seen - fv0), 64'd1);
        checkOutput("early_err_pulses", 64'(err_seen - err0), 64'd1);

        // Missing sync drops alignment; a further unsynced sample in HUNT
        // must not raise another error.
        $display("[TB] missing sync");
        err0 = err_seen;
        applyStimulus(1'b1, 1'b0, 8'h77);
        idleCycle();
        checkOutput("miss_sync_err", 64'(bus.sync_err), 64'd1);
        checkOutput("miss_ch_data", 64'(bus.ch_data), 64'h60504030);
        checkOutput("miss_frame_cnt", 64'(bus.frame_cnt), 64'd1);
        applyStimulus(1'b1, 1'b0, 8'h88);
        idleCycle();
        checkOutput("miss_err_pulses", 64'(err_seen - err0), 64'd1);
        sendFrame(32'h0F0E0D0C, 1);
        idleCycle();

        // Asynchronous reset between the 2nd and 3rd sample.
        $display("[TB] async reset mid-frame");
        applyStimulus(1'b1, 1'b1, 8'h0A);
        applyStimulus(1'b1, 1'b0, 8'h0B);
        @(posedge clk);
        #3;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        modelReset();
        #1;
        checkOutput("amid_ch_data", 64'(bus.ch_data), 64'd0);
        checkOutput("amid_slot", 64'(bus.slot), 64'd0);
        checkOutput("amid_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        sendFrame(32'h0D0C0B0A, 0);
        idleCycle();
        checkOutput("amid_resync_ch_data", 64'(bus.ch_data), 64'h0D0C0B0A);
        checkOutput("amid_resync_frame_cnt", 64'(bus.frame_cnt), 64'd1);

        // 255 more frames bring the counter to 256, i.e. wrapped to 0.
        $display("[TB] frame counter wrap");
        for (int n = 0; n < 255; n++) begin
            f = 32'($urandom);
            sendFrame(f, int'($urandom_range(0, 1)));
        end
        idleCycle();
        checkOutput("wrap_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        idleCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
